// File: rtl/sr_excite_drv.sv
// sr_excite_drv: write-side excitation driver for a bank of srff cells.
//
// Accepts a target word over valid/ready. Computes per-bit set/reset excitation
// against a shadow copy of the bank. Drives a one-cycle S/R pulse, waits
// SETTLE_CYCLES, then pulses done. S and R are never high on the same bit.
//
// Optional feature: define SR_EXCITE_VERIFY_EN to compare the bank readback
// (q_fb) with the target in CHECK. This drives err and resyncs the shadow from
// q_fb. Without the macro, q_fb is ignored and err is tied low.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid/ready target handshake; in_data is the target word
//   s_out, r_out   registered set/reset excitation to the bank
//   q_fb           bank q outputs (verify build only)
//   busy           transfer in progress (DRIVE..CHECK)
//   done           one-cycle completion pulse (CHECK)
//   err            last transfer failed verification (level)
module sr_excite_drv #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StDrive, StSettle, StCheck} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic [WIDTH-1:0]  r_q, r_d;

`ifdef SR_EXCITE_VERIFY_EN
  logic err_q, err_d;
`else
  logic unused_q_fb;
  assign unused_q_fb = ^q_fb;
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    // Excitation is only ever non-zero for the single DRIVE cycle.
    s_d      = '0;
    r_d      = '0;
`ifdef SR_EXCITE_VERIFY_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          target_d = in_data;
          s_d      = in_data & ~shadow_q;
          r_d      = ~in_data & shadow_q;
          state_d  = StDrive;
        end
      end
      StDrive: begin
        cnt_d   = CntW'(SETTLE_CYCLES - 1);
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StCheck: begin
`ifdef SR_EXCITE_VERIFY_EN
        err_d    = (q_fb != target_q);
        // Resync from the bank so a retry re-excites any bits that failed.
        shadow_d = q_fb;
`else
        shadow_d = target_q;
`endif
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      target_q <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      s_q      <= '0;
      r_q      <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      r_q      <= r_d;
    end
  end

`ifdef SR_EXCITE_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign s_out    = s_q;
  assign r_out    = r_q;
  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StCheck);

endmodule

// File: tb/tb_sr_excite_drv.sv
module tb_sr_excite_drv;
  localparam int unsigned W  = 8;
  localparam int unsigned SC = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] s_out, r_out;
  logic [W-1:0] q_fb = '0;
  logic         busy, done, err;

  sr_excite_drv #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .s_out    (s_out),
    .r_out    (r_out),
    .q_fb     (q_fb),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what the bank is believed to hold, and the last verdict.
  logic [W-1:0] m_shadow = '0;
  logic         m_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_s"}, 32'(s_out), 32'(0));
    check_eq({tag, "_r"}, 32'(r_out), 32'(0));
    check_eq({tag, "_ready"}, 32'(in_ready), 32'(1));
    check_eq({tag, "_busy"}, 32'(busy), 32'(0));
    check_eq({tag, "_done"}, 32'(done), 32'(0));
    check_eq({tag, "_err"}, 32'(err), 32'(m_err));
  endtask

  // One full transfer. qv is what the bank reads back during the transfer.
  // Cycle c counts negedges after the accept edge: c=1 DRIVE, c=SC+2 CHECK.
  task automatic do_write(input logic [W-1:0] d, input logic [W-1:0] qv);
    logic [W-1:0] es, er, new_shadow;
    logic         new_err;
    es = d & ~m_shadow;
    er = ~d & m_shadow;
`ifdef SR_EXCITE_VERIFY_EN
    new_err    = (qv != d);
    new_shadow = qv;
`else
    new_err    = 1'b0;
    new_shadow = d;
`endif
    @(negedge clk);
    check_eq("ready_pre", 32'(in_ready), 32'(1));
    in_valid = 1'b1;
    in_data  = d;
    q_fb     = qv;
    @(posedge clk);
    for (int c = 1; c <= int'(SC) + 3; c++) begin
      @(negedge clk);
      check_eq("s_and_r", 32'(s_out & r_out), 32'(0));
      if (c == 1) begin
        check_eq("drive_s", 32'(s_out), 32'(es));
        check_eq("drive_r", 32'(r_out), 32'(er));
      end else begin
        check_eq("quiet_s", 32'(s_out), 32'(0));
        check_eq("quiet_r", 32'(r_out), 32'(0));
      end
      check_eq("done", 32'(done), 32'(c == int'(SC) + 2));
      check_eq("busy", 32'(busy), 32'(c <= int'(SC) + 2));
      check_eq("ready", 32'(in_ready), 32'(c == int'(SC) + 3));
      check_eq("err", 32'(err), 32'((c == int'(SC) + 3) ? new_err : m_err));
      // Noise on the handshake while busy must be ignored.
      if (c <= int'(SC) + 2) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = W'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end
    m_shadow = new_shadow;
    m_err    = new_err;
  endtask

  initial begin
    logic [W-1:0] d, qv;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    do_write(8'hA5, 8'hA5);
    do_write(8'h0F, 8'h0F);
    do_write(8'h0F, 8'h0F);

`ifdef SR_EXCITE_VERIFY_EN
    do_write(8'h01, 8'h00);  // bank fails to take the bit
    do_write(8'h01, 8'h01);  // retry re-excites it
`endif

    // Reset during SETTLE: everything clears, no done follows.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    q_fb     = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    m_shadow = '0;
    m_err    = 1'b0;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(SC) + 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_done", 32'(done), 32'(0));
    end
    do_write(8'h03, 8'h03);

    for (int i = 0; i < 40; i++) begin
      d  = W'($urandom);
      qv = ($urandom_range(0, 3) == 0) ? W'($urandom) : d;
      do_write(d, qv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sr_excite_drv.md
# sr_excite_drv

Excitation driver for banks of SR flip-flops: the write-side counterpart to the `srff` storage element. It accepts a target word over a valid/ready handshake and computes the per-bit set/reset excitation against a shadow copy of the bank state. It then drives a one-cycle S/R pulse, waits a programmable settle time, and completes the transfer. It sits between control logic and any register bank built from `srff` cells, and guarantees the bank never sees the S=R=1 (invalid) combination.

## Interface
- `WIDTH`, 8, number of SR flip-flops driven.
- `SETTLE_CYCLES`, 2, cycles between the excitation pulse and completion. Legal range is ≥1.
- `clk` input 1: the single clock. All state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `in_data` holds a target word.
- `in_ready` output 1: block can accept a target.
- `in_data` input WIDTH: target value for the flip-flop bank.
- `s_out` output WIDTH: set excitation to the bank, registered.
- `r_out` output WIDTH: reset excitation to the bank, registered.
- `q_fb` input WIDTH: bank `q` outputs. Used only when verify is compiled in.
- `busy` output 1: a transfer is in progress (state ≠ IDLE).
- `done` output 1: single-cycle completion pulse.
- `err` output 1: last transfer failed verification.

## Operation
- The FSM has four states: IDLE, DRIVE, SETTLE and CHECK.
- **IDLE:**
  - `in_ready` = 1, decoded combinationally from the state.
  - On `in_valid & in_ready`: latch `in_data` into `target`, register the excitation, go to DRIVE.
- **Excitation, per bit:**
  - `s = target & ~shadow`
  - `r = ~target & shadow`
  - Unchanged bits get s=r=0, which is the hold condition.
  - Invariant: `(s_out & r_out) == 0` at all times.
- **DRIVE:** exactly one cycle. `s_out`/`r_out` carry the excitation. Next state is SETTLE, with the counter loaded to SETTLE_CYCLES-1.
- **SETTLE:**
  - `s_out` = `r_out` = 0.
  - Counter decrements each cycle; at 0 go to CHECK.
  - Counter width is `$clog2(SETTLE_CYCLES+1)`.
- **CHECK:** one cycle. `done` = 1, `err` is updated, shadow is updated (see Configuration). Next state is IDLE.
- **Zero-change targets** (target == shadow) still traverse DRIVE with s=r=0. Latency is uniform.
- **`err`** is a level. It is updated only in CHECK and held until the next CHECK.
- **`in_valid` outside IDLE** is ignored. No data is captured.
- **Reset**, asynchronous and applicable at any point including mid-transfer:
  - state = IDLE, `target` = 0, shadow = 0, counter = 0.
  - `s_out` = `r_out` = 0, `done` = 0, `err` = 0.
  - `busy` = 0, `in_ready` = 1.
  - A transfer interrupted by reset never produces `done`.
- **Shadow reset value** of 0 matches the `srff` power-up value q=0.

## Timing
- Accept at rising edge k.
- DRIVE is the cycle after edge k. `s_out`/`r_out` are valid there, so the bank samples them at edge k+1.
- SETTLE covers cycles k+1 … k+SETTLE_CYCLES.
- CHECK (`done` high) occurs in the cycle after edge k+1+SETTLE_CYCLES.
- Accept-to-`done` latency is 2+SETTLE_CYCLES cycles.
- `in_ready` returns high in the cycle after CHECK. The earliest next accept is the edge that ends that cycle.
- Back-to-back throughput is one transfer per 3+SETTLE_CYCLES cycles.
- `busy` is high from DRIVE through CHECK inclusive.

## Configuration
- **`SR_EXCITE_VERIFY_EN` defined:**
  - In CHECK: `err <= (q_fb != target)` and `shadow <= q_fb`.
  - Resyncing the shadow from the bank means a retry of the same target re-excites the failed bits.
- **`SR_EXCITE_VERIFY_EN` undefined:**
  - `q_fb` is ignored and `err` is tied to 0.
  - `shadow <= target` in CHECK.

## Test plan
- **Reset:** assert `rst_n`=0 mid-idle. Require `s_out`=`r_out`=0x00, `in_ready`=1, `busy`=0, `done`=0, `err`=0.
- **First write** (WIDTH=8, SETTLE_CYCLES=2): accept 0xA5 from shadow 0x00. DRIVE cycle shows `s_out`=0xA5, `r_out`=0x00. `done` pulses exactly 4 cycles after the accept edge.
- **Mixed update:** then write 0x0F. DRIVE shows `s_out`=0x0A, `r_out`=0xA0. `s_out & r_out` must be 0 on every cycle of the test.
- **Repeat target:** write 0x0F again. DRIVE shows `s_out`=`r_out`=0x00, `done` still at 4 cycles, and `in_valid` pulses during `busy` are ignored.
- **Verify failure** (`SR_EXCITE_VERIFY_EN`): `q_fb` forced to 0x00, write 0x01. Require `err`=1 at CHECK. A retry of 0x01 shows `s_out`=0x01 again; with `q_fb`=0x01 the retry clears `err` to 0.
- **Reset mid-transfer:** assert `rst_n`=0 during SETTLE. Outputs clear immediately, no `done` follows, and the next write of 0x03 shows `s_out`=0x03 (shadow was cleared).
